// File: rtl/pio_seq_ctrl.sv
// pio_seq_ctrl: replays a table of values to a PIO register with per-entry dwell.
// Define PIO_SEQ_IRQ_EN to add the irq output and the CTRL.IRQ_EN bit.
module pio_seq_ctrl #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  cfg_address,
    input  logic        cfg_chipselect,
    input  logic        cfg_write_n,
    input  logic [31:0] cfg_writedata,
    output logic [31:0] cfg_readdata,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest
`ifdef PIO_SEQ_IRQ_EN
    ,
    output logic        irq
`endif
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DWELL} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  index_q, index_d;
    logic [15:0]       counter_q, counter_d;
    logic [4:0]        length_q, length_d;
    logic              loop_q, loop_d;
    logic              done_q, done_d;
    logic              stop_pend_q, stop_pend_d;
    logic [DATA_W-1:0] tbl_val_q [DEPTH];
    logic [DATA_W-1:0] tbl_val_d [DEPTH];
    logic [15:0]       tbl_dwl_q [DEPTH];
    logic [15:0]       tbl_dwl_d [DEPTH];
`ifdef PIO_SEQ_IRQ_EN
    logic              irq_en_q, irq_en_d;
`endif

    logic             wr, wr_ctrl, wr_stat, wr_len, wr_tbl;
    logic             busy, start, stop, last;
    logic [IDX_W-1:0] tbl_idx;
    logic             unused_ok;

    assign wr      = cfg_chipselect & ~cfg_write_n;
    assign wr_ctrl = wr && (cfg_address == 5'd0);
    assign wr_stat = wr && (cfg_address == 5'd1);
    assign wr_len  = wr && (cfg_address == 5'd2);
    assign wr_tbl  = wr && cfg_address[4]
                     && ({1'b0, cfg_address[3:0]} < 5'(DEPTH));
    assign tbl_idx = cfg_address[IDX_W-1:0];
    assign start   = wr_ctrl & cfg_writedata[0];
    assign stop    = wr_ctrl & cfg_writedata[2];
    assign busy    = (state_q != S_IDLE);
    assign last    = ((5'(index_q) + 5'd1) == length_q);

    assign m_address = 2'b00;
    assign unused_ok = ^{cfg_writedata, cfg_address};

`ifdef PIO_SEQ_IRQ_EN
    assign irq = done_q & irq_en_q;
`endif

    // Config read mux; unmapped addresses and spare bits read zero.
    always_comb begin
        cfg_readdata = '0;
        if (cfg_address == 5'd0) begin
            cfg_readdata[1] = loop_q;
`ifdef PIO_SEQ_IRQ_EN
            cfg_readdata[3] = irq_en_q;
`endif
        end else if (cfg_address == 5'd1) begin
            cfg_readdata[0]   = busy;
            cfg_readdata[1]   = done_q;
            cfg_readdata[7:4] = 4'(index_q);
        end else if (cfg_address == 5'd2) begin
            cfg_readdata[4:0] = length_q;
        end else if (cfg_address[4]
                     && ({1'b0, cfg_address[3:0]} < 5'(DEPTH))) begin
            cfg_readdata[DATA_W-1:0] = tbl_val_q[tbl_idx];
            cfg_readdata[31:16]      = tbl_dwl_q[tbl_idx];
        end
    end

    // Config register updates; table and length are frozen while busy.
    always_comb begin
        length_d  = length_q;
        loop_d    = loop_q;
        tbl_val_d = tbl_val_q;
        tbl_dwl_d = tbl_dwl_q;
`ifdef PIO_SEQ_IRQ_EN
        irq_en_d  = irq_en_q;
        if (wr_ctrl) irq_en_d = cfg_writedata[3];
`endif
        if (wr_ctrl) loop_d = cfg_writedata[1];
        if (wr_len && !busy) begin
            length_d = (cfg_writedata[4:0] > 5'(DEPTH))
                       ? 5'(DEPTH) : cfg_writedata[4:0];
        end
        if (wr_tbl && !busy) begin
            tbl_val_d[tbl_idx] = cfg_writedata[DATA_W-1:0];
            tbl_dwl_d[tbl_idx] = cfg_writedata[31:16];
        end
    end

    // Sequencer next state and master bus drive; DONE set beats clear.
    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        counter_d    = counter_q;
        stop_pend_d  = stop_pend_q;
        done_d       = done_q;
        m_chipselect = 1'b0;
        m_write_n    = 1'b1;
        m_writedata  = '0;
        if (wr_stat && cfg_writedata[1]) done_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                stop_pend_d = 1'b0;
                if (start && !stop && (length_q != 5'd0)) begin
                    state_d = S_WRITE;
                    index_d = '0;
                    done_d  = 1'b0;
                end
            end
            S_WRITE: begin
                m_chipselect = 1'b1;
                m_write_n    = 1'b0;
                m_writedata  = 32'(tbl_val_q[index_q]);
                if (stop) stop_pend_d = 1'b1;
                if (!m_waitrequest) begin
                    if (stop || stop_pend_q) begin
                        state_d     = S_IDLE;
                        stop_pend_d = 1'b0;
                    end else begin
                        state_d   = S_DWELL;
                        counter_d = tbl_dwl_q[index_q];
                    end
                end
            end
            S_DWELL: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (counter_q == 16'd0) begin
                    if (!last) begin
                        index_d = index_q + IDX_W'(1);
                        state_d = S_WRITE;
                    end else if (loop_q) begin
                        index_d = '0;
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    counter_d = counter_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and register storage, all cleared by the async reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            index_q     <= '0;
            counter_q   <= '0;
            length_q    <= '0;
            loop_q      <= 1'b0;
            done_q      <= 1'b0;
            stop_pend_q <= 1'b0;
`ifdef PIO_SEQ_IRQ_EN
            irq_en_q    <= 1'b0;
`endif
            for (int i = 0; i < DEPTH; i++) begin
                tbl_val_q[i] <= '0;
                tbl_dwl_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            counter_q   <= counter_d;
            length_q    <= length_d;
            loop_q      <= loop_d;
            done_q      <= done_d;
            stop_pend_q <= stop_pend_d;
`ifdef PIO_SEQ_IRQ_EN
            irq_en_q    <= irq_en_d;
`endif
            tbl_val_q   <= tbl_val_d;
            tbl_dwl_q   <= tbl_dwl_d;
        end
    end
endmodule
